logic_unit_pipe: RTL
====================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 1..64).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port in_valid  input  1  operand beat offered.
REQ-005 Port in_ready  output  1  block can accept a beat this cycle.
REQ-006 Port a  input  WIDTH  operand A.
REQ-007 Port b  input  WIDTH  operand B.
REQ-008 Port op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-009 Port out_valid  output  1  result beat available.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port y  output  WIDTH  result.
REQ-012 Port zero  output  1  y is all zeros.
REQ-013 Port parity  output  1  XOR-reduction of y.

Function
REQ-014 Input handshake: beat accepted iff in_valid && in_ready at a rising edge; output handshake: beat consumed iff out_valid && out_ready.
REQ-015 Accepted beat computes y = a op b bitwise, full WIDTH, no carry or truncation; zero and parity are derived from that y.
REQ-016 Results are held in a 2-entry FIFO (entry = y, zero, parity); head entry drives y/zero/parity when out_valid=1.
REQ-017 Latency: beat accepted at edge N appears with out_valid=1 after edge N (visible in cycle N+1) when the FIFO was empty.
REQ-018 in_ready shall be a registered signal, equal to 1 when occupancy < 2 after the current edge's updates; no combinational path from out_ready to in_ready.
REQ-019 Occupancy update: push only -> +1; pop only -> -1; push and pop together -> unchanged; order strictly FIFO.
REQ-020 Full (occupancy 2): in_ready=0, in_valid ignored; a pop frees one slot and sets in_ready=1 the next cycle.
REQ-021 Empty: out_valid=0; out_ready ignored; y/zero/parity hold their last values.
REQ-022 While out_valid=1 and out_ready=0, y/zero/parity shall stay stable.
REQ-023 op, a and b are sampled only on an accepted beat; changes at other times have no effect.

Reset
REQ-024 rst_n=0 at a rising edge empties the FIFO, discarding in-flight entries, regardless of handshakes that cycle.
REQ-025 Reset values: out_valid=0, y=0, zero=0, parity=0, in_ready=1 from the first cycle after the reset edge.

Configuration
REQ-026 Macro LOGIC_UNIT_PIPE_STATS_EN defined: adds output port txn_count (output, 16 bits) counting output handshakes, reset to 0, wrapping 16'hFFFF -> 0.
REQ-027 Macro LOGIC_UNIT_PIPE_STATS_EN undefined: port txn_count and its counter are absent; all other behaviour is identical.

Structure
REQ-028 Package logic_unit_pkg shall hold the op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND) and the op-select width constant.
REQ-029 Sub-module logic_unit_core shall be combinational (a, b, op -> y, zero, parity, WIDTH-parametrised) and instantiated once ahead of the FIFO.

Verification (WIDTH=8)
REQ-030 Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, y=8'h00, zero=0, parity=0, in_ready=1 after release.
REQ-031 Ops: a=8'hF0, b=8'hCC, out_ready=1, op 00/01/10/11 on consecutive beats -> y=8'hC0/8'hFC/8'h3C/8'h3F, one cycle after each accept, back-to-back.
REQ-032 Flags: AND a=8'h0F, b=8'hF0 -> y=8'h00, zero=1, parity=0; XOR a=8'h01, b=8'h00 -> y=8'h01, zero=0, parity=1.
REQ-033 Backpressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0, y stable. Set out_ready=1 -> results emerge in order, and the third beat is accepted the cycle after in_ready returns to 1.
REQ-034 Reset mid-operation: FIFO holding 2 entries, pulse rst_n=0 for one cycle -> out_valid=0 next cycle and no stale result emitted afterwards.
REQ-035 Stats (macro defined): 65537 output handshakes -> txn_count=16'h0001; macro undefined -> build has no txn_count port and tests REQ-030 to REQ-034 pass unchanged.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared constants for the logic unit pipeline: op encodings and widths.
package logic_unit_pkg;

  localparam int unsigned OP_W       = 2;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned TXN_W      = 16;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise logic unit: y = a op b, plus zero and parity flags.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

  assign zero   = ~|y;
  assign parity = ^y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Logic unit followed by a 2-entry result FIFO with valid/ready handshakes.
// Define LOGIC_UNIT_PIPE_STATS_EN to add the txn_count output-handshake counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  ,
  output logic [TXN_W-1:0] txn_count
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
  } entry_t;

  entry_t           res_c;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             in_ready_q;
  logic             in_ready_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             push_c;
  logic             pop_c;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .op     (op),
    .y      (res_c.y),
    .zero   (res_c.zero),
    .parity (res_c.parity)
  );

  assign push_c = in_valid & in_ready_q;
  assign pop_c  = out_valid_q & out_ready;

  // Slot 0 is always the head; it keeps its value when the FIFO drains so outputs hold.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10: begin
        if (count_q == CNT_W'(0)) mem_d[0] = res_c;
        else                      mem_d[1] = res_c;
        count_d = count_q + CNT_W'(1);
      end
      2'b01: begin
        if (count_q == CNT_W'(FIFO_DEPTH)) mem_d[0] = mem_q[1];
        count_d = count_q - CNT_W'(1);
      end
      2'b11: begin
        if (count_q == CNT_W'(1)) begin
          mem_d[0] = res_c;
        end else begin
          mem_d[0] = mem_q[1];
          mem_d[1] = res_c;
        end
      end
      default: ;
    endcase
    in_ready_d  = (count_d < CNT_W'(FIFO_DEPTH));
    out_valid_d = (count_d != CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = mem_q[0].y;
  assign zero      = mem_q[0].zero;
  assign parity    = mem_q[0].parity;

`ifdef LOGIC_UNIT_PIPE_STATS_EN
  logic [TXN_W-1:0] txn_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     txn_q <= '0;
    else if (pop_c) txn_q <= txn_q + TXN_W'(1);
  end

  assign txn_count = txn_q;
`endif

endmodule
